// File: rtl/branch_outcome_tracker.sv
// In-order tracker of issued branch predictions: resolves the oldest entry, drives table update,
// history restore and front-end flush. Optional BOT_STATS_EN adds branch/mispredict counters.
module branch_outcome_tracker #(
  parameter int DEPTH = 4,
  parameter int PC_W  = 4,
  parameter int GHR_W = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             pred_valid,
  input  logic [PC_W-1:0]  pred_pc,
  input  logic             pred_taken,
  input  logic [GHR_W-1:0] pred_ghr,
  output logic             pred_ready,
  input  logic             res_valid,
  input  logic             res_taken,
  output logic             upd_valid,
  output logic [PC_W-1:0]  upd_idx,
  output logic             upd_taken,
  output logic             mispredict,
  output logic [GHR_W-1:0] flush_ghr,
  output logic             res_err
`ifdef BOT_STATS_EN
  ,
  output logic [15:0]      stat_branches,
  output logic [15:0]      stat_mispred
`endif
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [PTR_W-1:0] PTR_ONE = PTR_W'(1);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DEPTH);

  typedef struct packed {
    logic [PC_W-1:0]  pc;
    logic             taken;
    logic [GHR_W-1:0] ghr;
  } entry_t;

  typedef enum logic {
    ST_RUN   = 1'b0,
    ST_FLUSH = 1'b1
  } state_t;

  state_t            state_q, state_d;
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  entry_t            mem_q [DEPTH];
  entry_t            head;
  entry_t            wr_entry;

  logic              full, empty;
  logic              push, pop, miss, err_hit, wr_en;

  logic              upd_valid_q, upd_valid_d;
  logic [PC_W-1:0]   upd_idx_q, upd_idx_d;
  logic              upd_taken_q, upd_taken_d;
  logic              mispredict_q, mispredict_d;
  logic [GHR_W-1:0]  flush_ghr_q, flush_ghr_d;
  logic              res_err_q, res_err_d;

  always_comb begin
    full       = (cnt_q == CNT_FULL);
    empty      = (cnt_q == '0);
    pred_ready = !full && (state_q == ST_RUN);
    push       = pred_valid && pred_ready;
    // FLUSH always follows a clear, but gate explicitly so a resolve there is an error
    pop        = res_valid && !empty && (state_q == ST_RUN);
    err_hit    = res_valid && !pop;
    head       = mem_q[rd_ptr_q];
    miss       = pop && (head.taken != res_taken);
    wr_en      = push && !miss;
    wr_entry   = '{pc: pred_pc, taken: pred_taken, ghr: pred_ghr};
  end

  always_comb begin
    state_d  = state_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    cnt_d    = cnt_q;
    if (miss) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      cnt_d    = '0;
      state_d  = ST_FLUSH;
    end else begin
      if (state_q == ST_FLUSH) begin
        state_d = ST_RUN;
      end
      if (push) begin
        wr_ptr_d = wr_ptr_q + PTR_ONE;
      end
      if (pop) begin
        rd_ptr_d = rd_ptr_q + PTR_ONE;
      end
      case ({push, pop})
        2'b10:   cnt_d = cnt_q + CNT_ONE;
        2'b01:   cnt_d = cnt_q - CNT_ONE;
        default: cnt_d = cnt_q;
      endcase
    end
  end

  always_comb begin
    upd_valid_d  = pop;
    upd_idx_d    = upd_idx_q;
    upd_taken_d  = upd_taken_q;
    flush_ghr_d  = flush_ghr_q;
    mispredict_d = miss;
    res_err_d    = res_err_q || err_hit;
    if (pop) begin
      upd_idx_d   = head.pc ^ head.ghr;
      upd_taken_d = res_taken;
      flush_ghr_d = {res_taken, head.ghr[GHR_W-1:1]};
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q      <= ST_RUN;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      cnt_q        <= '0;
      upd_valid_q  <= 1'b0;
      upd_idx_q    <= '0;
      upd_taken_q  <= 1'b0;
      mispredict_q <= 1'b0;
      flush_ghr_q  <= '0;
      res_err_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      cnt_q        <= cnt_d;
      upd_valid_q  <= upd_valid_d;
      upd_idx_q    <= upd_idx_d;
      upd_taken_q  <= upd_taken_d;
      mispredict_q <= mispredict_d;
      flush_ghr_q  <= flush_ghr_d;
      res_err_q    <= res_err_d;
    end
  end

  // Storage needs no reset: occupancy alone decides which slots are live
  always_ff @(posedge clk) begin
    if (reset && wr_en) begin
      mem_q[wr_ptr_q] <= wr_entry;
    end
  end

  assign upd_valid  = upd_valid_q;
  assign upd_idx    = upd_idx_q;
  assign upd_taken  = upd_taken_q;
  assign mispredict = mispredict_q;
  assign flush_ghr  = flush_ghr_q;
  assign res_err    = res_err_q;

`ifdef BOT_STATS_EN
  logic [15:0] br_cnt_q, br_cnt_d;
  logic [15:0] mp_cnt_q, mp_cnt_d;

  always_comb begin
    br_cnt_d = br_cnt_q;
    mp_cnt_d = mp_cnt_q;
    if (pop && (br_cnt_q != 16'hFFFF)) begin
      br_cnt_d = br_cnt_q + 16'd1;
    end
    if (miss && (mp_cnt_q != 16'hFFFF)) begin
      mp_cnt_d = mp_cnt_q + 16'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      br_cnt_q <= '0;
      mp_cnt_q <= '0;
    end else begin
      br_cnt_q <= br_cnt_d;
      mp_cnt_q <= mp_cnt_d;
    end
  end

  assign stat_branches = br_cnt_q;
  assign stat_mispred  = mp_cnt_q;
`endif

endmodule
